// File: rtl/image_arb_pkg.sv
// Shared defaults and the owner encoding for the image RAM arbiter.
package image_arb_pkg;

    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 784;
    localparam int DEF_MAX_BURST = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CNN = 2'd1,
        OWN_WR  = 2'd2
    } owner_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_CNN) ? OWN_WR : OWN_CNN;
    endfunction

endpackage

// File: rtl/image_ram_arbiter.sv
// Single-port image RAM arbiter: display reads preempt everything, classifier
// reads and loader writes share the remaining cycles under a burst-fair FSM.
module image_ram_arbiter
    import image_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              cnn_req,
    input  logic [ADDR_W-1:0] cnn_addr,
    output logic              cnn_gnt,
    output logic              cnn_valid,
    output logic [DATA_W-1:0] cnn_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int                BURST_W   = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
    localparam logic [ADDR_W:0]    DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    owner_e              r_state;
    owner_e              r_last;
    logic [BURST_W-1:0]  r_burst;
    logic                r_rd_vld;
    logic                r_rd_tag;
    logic                r_rd_oor;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    owner_e              w_sel;
    logic                w_disp_go;
    logic                w_low_en;
    logic                w_burst_full;
    logic                w_disp_in;
    logic                w_cnn_in;
    logic                w_wr_in;
    logic                w_rd_issue;
    logic                w_rd_tag;
    logic                w_rd_oor;
    logic                w_other_req;
    logic [BURST_W-1:0]  w_cnt;
    logic [DATA_W-1:0]   w_rd_data;

    assign w_disp_go    = rst_n & disp_req;
    assign w_low_en     = rst_n & ~disp_req;
    assign w_burst_full = (r_burst >= BURST_MAX);
    assign w_disp_in    = ({1'b0, disp_addr} < DEPTH_L);
    assign w_cnn_in     = ({1'b0, cnn_addr}  < DEPTH_L);
    assign w_wr_in      = ({1'b0, wr_addr}   < DEPTH_L);

    always_comb begin
        w_sel = IDLE;
        case (r_state)
            IDLE: begin
                if (cnn_req && wr_req)
                    w_sel = other_owner(r_last);
                else if (cnn_req)
                    w_sel = OWN_CNN;
                else if (wr_req)
                    w_sel = OWN_WR;
            end
            OWN_CNN: begin
                if (cnn_req && !(w_burst_full && wr_req))
                    w_sel = OWN_CNN;
                else if (wr_req)
                    w_sel = OWN_WR;
            end
            OWN_WR: begin
                if (wr_req && !(w_burst_full && cnn_req))
                    w_sel = OWN_WR;
                else if (cnn_req)
                    w_sel = OWN_CNN;
            end
            default: w_sel = IDLE;
        endcase
    end

    assign cnn_gnt = w_low_en && (w_sel == OWN_CNN);
    assign wr_gnt  = w_low_en && (w_sel == OWN_WR);

    // Burst count includes the beat granted this cycle; a fresh owner starts at 1.
    assign w_cnt       = (r_state == w_sel) ? (w_burst_full ? BURST_MAX : r_burst + BURST_W'(1))
                                            : BURST_W'(1);
    assign w_other_req = (w_sel == OWN_CNN) ? wr_req : cnn_req;

    always_comb begin
        ram_ce     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = r_addr;
        ram_wdata  = r_wdata;
        w_rd_issue = 1'b0;
        w_rd_tag   = 1'b0;
        w_rd_oor   = 1'b0;
        if (w_disp_go) begin
            ram_ce     = w_disp_in;
            ram_addr   = disp_addr;
            w_rd_issue = 1'b1;
            w_rd_oor   = ~w_disp_in;
        end else if (cnn_gnt) begin
            ram_ce     = w_cnn_in;
            ram_addr   = cnn_addr;
            w_rd_issue = 1'b1;
            w_rd_tag   = 1'b1;
            w_rd_oor   = ~w_cnn_in;
        end else if (wr_gnt) begin
            ram_ce     = w_wr_in;
            ram_we     = w_wr_in;
            ram_addr   = wr_addr;
            ram_wdata  = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last   <= OWN_WR;
            r_burst  <= '0;
            r_rd_vld <= 1'b0;
            r_rd_tag <= 1'b0;
            r_rd_oor <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_addr   <= ram_addr;
            r_wdata  <= ram_wdata;
            r_rd_vld <= w_rd_issue;
            r_rd_tag <= w_rd_tag;
            r_rd_oor <= w_rd_oor;
            // Display-stolen cycles leave owner, burst and history untouched.
            if (!disp_req) begin
                if (w_sel == IDLE) begin
                    r_state <= IDLE;
                    r_burst <= '0;
                end else begin
                    r_last <= w_sel;
                    if ((w_cnt >= BURST_MAX) && w_other_req) begin
                        r_state <= other_owner(w_sel);
                        r_burst <= '0;
                    end else begin
                        r_state <= w_sel;
                        r_burst <= w_cnt;
                    end
                end
            end
        end
    end

    assign disp_valid = r_rd_vld & ~r_rd_tag;
    assign cnn_valid  = r_rd_vld &  r_rd_tag;
    assign w_rd_data  = r_rd_oor ? '0 : ram_rdata;
    assign disp_data  = disp_valid ? w_rd_data : '0;
    assign cnn_data   = cnn_valid  ? w_rd_data : '0;

endmodule
